// File: rtl/key_pio_in.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_pio_in                                                    |
// | Purpose  : Avalon-MM key input port: sync, debounce, edge capture, irq.  |
// |            Optional macro KEY_PIO_BIT_CLEAR_EN: write-1-to-clear capture.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int                 c_CNT_W     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [1:0]         c_ADDR_DATA = 2'd0;
    localparam logic [1:0]         c_ADDR_MASK = 2'd2;
    localparam logic [1:0]         c_ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0]   r_sync1_q,      r_sync1_d;
    logic [WIDTH-1:0]   r_sync2_q,      r_sync2_d;
    logic [WIDTH-1:0]   r_stable_q,     r_stable_d;
    logic [WIDTH-1:0]   r_stable_dly_q, r_stable_dly_d;
    logic [c_CNT_W-1:0] r_cnt_q [WIDTH];
    logic [c_CNT_W-1:0] r_cnt_d [WIDTH];
    logic [WIDTH-1:0]   r_edge_cap_q,   r_edge_cap_d;
    logic [WIDTH-1:0]   r_irq_mask_q,   r_irq_mask_d;
    logic [WIDTH-1:0]   r_readdata_q,   r_readdata_d;
    logic               r_irq_q,        r_irq_d;

    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_event;
    logic [WIDTH-1:0]   w_clr;
    logic [WIDTH-1:0]   w_rd_mux;
    logic               w_rd_en;
    logic               w_wr_en;

    // Both strobes low counts as a write, so a read needs write_n high.
    assign w_wr_en = chipselect & ~write_n;
    assign w_rd_en = chipselect & ~read_n & write_n;

    always_comb begin
        r_sync1_d = in_port;
        r_sync2_d = r_sync1_q;
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        r_stable_d = r_stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            r_cnt_d[i] = '0;
            if (r_sync2_q[i] != r_stable_q[i]) begin
                if (r_cnt_q[i] == c_CNT_MAX) begin
                    r_stable_d[i] = r_sync2_q[i];
                end else begin
                    r_cnt_d[i] = r_cnt_q[i] + c_CNT_ONE;
                end
            end
        end
    end

    assign r_stable_dly_d = r_stable_q;
    assign w_rise         = r_stable_q & ~r_stable_dly_q;
    assign w_fall         = ~r_stable_q & r_stable_dly_q;

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_event = w_rise;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_event = w_fall;
        end else begin : g_edge_any
            assign w_event = w_rise | w_fall;
        end
    endgenerate

    always_comb begin
        w_clr = '0;
        if (w_wr_en && (address == c_ADDR_EDGE)) begin
`ifdef KEY_PIO_BIT_CLEAR_EN
            w_clr = writedata;
`else
            w_clr = '1;
`endif
        end
    end

    // Set has priority over clear on the same bit.
    always_comb begin
        r_edge_cap_d = (r_edge_cap_q & ~w_clr) | w_event;
        r_irq_mask_d = r_irq_mask_q;
        if (w_wr_en && (address == c_ADDR_MASK)) begin
            r_irq_mask_d = writedata;
        end
        r_irq_d = |(r_edge_cap_d & r_irq_mask_d);
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_ADDR_DATA: w_rd_mux = r_stable_q;
            c_ADDR_MASK: w_rd_mux = r_irq_mask_q;
            c_ADDR_EDGE: w_rd_mux = r_edge_cap_q;
            default:     w_rd_mux = '0;
        endcase
        r_readdata_d = w_rd_en ? w_rd_mux : r_readdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q      <= '1;
            r_sync2_q      <= '1;
            r_stable_q     <= '1;
            r_stable_dly_q <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt_q[i] <= '0;
            end
            r_edge_cap_q   <= '0;
            r_irq_mask_q   <= '0;
            r_readdata_q   <= '0;
            r_irq_q        <= 1'b0;
        end else begin
            r_sync1_q      <= r_sync1_d;
            r_sync2_q      <= r_sync2_d;
            r_stable_q     <= r_stable_d;
            r_stable_dly_q <= r_stable_dly_d;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt_q[i] <= r_cnt_d[i];
            end
            r_edge_cap_q   <= r_edge_cap_d;
            r_irq_mask_q   <= r_irq_mask_d;
            r_readdata_q   <= r_readdata_d;
            r_irq_q        <= r_irq_d;
        end
    end

    assign readdata = r_readdata_q;
    assign irq      = r_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_key_pio_in.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_key_pio_in                                                 |
// | Purpose  : Directed plus random bench for key_pio_in, DEBOUNCE_CYCLES=4. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_key_pio_in;

    localparam int W  = 4;
    localparam int DC = 4;
    localparam int ET = 1;

    logic         clk;
    logic         reset;
    logic         chipselect;
    logic [1:0]   address;
    logic         read_n;
    logic         write_n;
    logic [W-1:0] writedata;
    logic [W-1:0] readdata;
    logic [W-1:0] in_port;
    logic         irq;

    int checks = 0;
    int errors = 0;

    key_pio_in #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_TYPE      (ET)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .chipselect(chipselect),
        .address   (address),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stable flips once the last DC synchronised samples all
    // disagree with it; samples seen before a reset are forgotten.
    logic [W-1:0] m_s1, m_s2, m_stable, m_stable_prev, m_ec, m_mask, m_rd;
    logic         m_irq;
    logic [W-1:0] m_hist[$];

`ifdef KEY_PIO_BIT_CLEAR_EN
    localparam logic [W-1:0] CLR_EXP = 4'h2;
`else
    localparam logic [W-1:0] CLR_EXP = 4'h0;
`endif

    task automatic model_step();
        logic [W-1:0] n_stable, ev, clr, n_ec, n_mask, n_rd;
        bit           all_diff, wr, rd;
        if (reset) begin
            m_s1 = '1; m_s2 = '1; m_stable = '1; m_stable_prev = '1;
            m_ec = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
            m_hist.delete();
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > DC) void'(m_hist.pop_front());
            n_stable = m_stable;
            if (m_hist.size() == DC) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
                    if (all_diff) n_stable[b] = ~m_stable[b];
                end
            end
            case (ET)
                0:       ev = m_stable & ~m_stable_prev;
                1:       ev = ~m_stable & m_stable_prev;
                default: ev = m_stable ^ m_stable_prev;
            endcase
            wr  = chipselect && !write_n;
            rd  = chipselect && !read_n && write_n;
            clr = '0;
            if (wr && address == 2'd3) begin
`ifdef KEY_PIO_BIT_CLEAR_EN
                clr = writedata;
`else
                clr = '1;
`endif
            end
            n_ec   = (m_ec & ~clr) | ev;
            n_mask = (wr && address == 2'd2) ? writedata : m_mask;
            n_rd   = m_rd;
            if (rd) begin
                case (address)
                    2'd0:    n_rd = m_stable;
                    2'd2:    n_rd = m_mask;
                    2'd3:    n_rd = m_ec;
                    default: n_rd = '0;
                endcase
            end
            m_irq         = |(n_ec & n_mask);
            m_s2          = m_s1;
            m_s1          = in_port;
            m_stable_prev = m_stable;
            m_stable      = n_stable;
            m_ec          = n_ec;
            m_mask        = n_mask;
            m_rd          = n_rd;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_readdata", 32'(readdata), 32'(m_rd));
        chk("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle_bus();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = 2'd0; writedata = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
        step();
        idle_bus();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [W-1:0] d);
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
        step();
        d = readdata;
        idle_bus();
    endtask

    initial begin
        logic [W-1:0] d;
        int           r;
        idle_bus();
        in_port = 4'hF;
        reset   = 1'b1;

        // Reset values
        repeat (3) step();
        reset = 1'b0;
        bus_read(2'd0, d); chk("rst_data", 32'(d), 32'hF);
        bus_read(2'd2, d); chk("rst_mask", 32'(d), 32'h0);
        bus_read(2'd3, d); chk("rst_edge", 32'(d), 32'h0);
        bus_read(2'd1, d); chk("rsvd_read", 32'(d), 32'h0);

        // Glitch of DC-1 cycles is rejected
        in_port = 4'hE;
        repeat (DC - 1) step();
        in_port = 4'hF;
        repeat (8) step();
        bus_read(2'd0, d); chk("glitch_data", 32'(d), 32'hF);
        bus_read(2'd3, d); chk("glitch_edge", 32'(d), 32'h0);

        // Debounced press with bit 0 unmasked
        bus_write(2'd2, 4'h1);
        bus_read(2'd2, d); chk("mask_read", 32'(d), 32'h1);
        in_port = 4'hE;
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        repeat (2 + DC) begin
            step();
            chk("press_wait", 32'(readdata), 32'hF);
        end
        step();
        chk("press_data", 32'(readdata), 32'hE);
        chk("press_irq", 32'(irq), 32'h1);
        idle_bus();
        bus_read(2'd3, d); chk("press_edge", 32'(d), 32'h1);

        // Mask toggling
        bus_write(2'd2, 4'h0); chk("mask_off_irq", 32'(irq), 32'h0);
        bus_write(2'd2, 4'h1); chk("mask_on_irq", 32'(irq), 32'h1);

        // Clear behaviour
        in_port = 4'hC;
        repeat (8) step();
        bus_read(2'd3, d); chk("edge_two", 32'(d), 32'h3);
        bus_write(2'd3, 4'h1);
        bus_read(2'd3, d); chk("clear_mode", 32'(d), 32'(CLR_EXP));
        bus_write(2'd3, 4'hF);
        in_port = 4'hF;
        repeat (8) step();
        bus_read(2'd3, d); chk("release_no_edge", 32'(d), 32'h0);
        chk("release_irq", 32'(irq), 32'h0);

        // Set wins over a coincident clear
        in_port = 4'hE;
        repeat (2 + DC) step();
        bus_write(2'd3, 4'hF);
        bus_read(2'd3, d); chk("set_wins", 32'(d), 32'h1);

        // Reset with a debounce count in flight
        in_port = 4'hF;
        repeat (8) step();
        bus_write(2'd3, 4'hF);
        bus_write(2'd2, 4'h0);
        in_port = 4'hE;
        repeat (4) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        repeat (2 + DC) begin
            step();
            chk("requal_wait", 32'(readdata), 32'hF);
        end
        step();
        chk("requal_data", 32'(readdata), 32'hE);
        idle_bus();
        bus_read(2'd2, d); chk("requal_mask", 32'(d), 32'h0);
        bus_read(2'd3, d); chk("requal_edge", 32'(d), 32'h1);
        chk("requal_irq", 32'(irq), 32'h0);

        // Random traffic against the model
        repeat (800) begin
            if ($urandom_range(5) == 0) in_port = W'($urandom);
            reset = ($urandom_range(199) == 0);
            r = $urandom_range(3);
            address   = 2'($urandom);
            writedata = W'($urandom);
            chipselect = (r != 0) || ($urandom_range(1) == 0);
            read_n     = !(r == 1 || r == 3);
            write_n    = !(r == 2 || r == 3);
            step();
        end
        reset = 1'b0;
        idle_bus();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
